// File: rtl/he_stream_eq.sv
// Two-pass streaming histogram equaliser: pass 1 builds the histogram, then CDF and LUT are
// computed serially; pass 2 streams LUT-mapped pixels. Define HE_CLIP_EN for bin clipping.
module he_stream_eq #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 660,
  parameter int unsigned IMG_H = 440,
  parameter int unsigned CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] clip_limit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NB     = 2 ** PIX_W;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned NUM_W  = CNT_W + PIX_W;
  localparam int unsigned DCNT_W = $clog2(NUM_W + 1);
  localparam logic [CNT_W-1:0]  LastPix = CNT_W'(NPIX - 1);
  localparam logic [PIX_W-1:0]  MaxBin  = '1;
  localparam logic [DCNT_W-1:0] DivLast = DCNT_W'(NUM_W - 1);

  typedef enum logic [2:0] {StIdle, StClear, StHist, StCdf, StLut, StMap, StDone} state_e;

  state_e             state;
  logic [CNT_W-1:0]   hist [NB];  // histogram, overwritten in place by the CDF
  logic [PIX_W-1:0]   lut  [NB];
  logic [PIX_W-1:0]   bin;
  logic [CNT_W-1:0]   pix_cnt, cdf_run, cdf_min, total;
  logic               found, map_open, div_busy;
  logic [DCNT_W-1:0]  div_cnt;
  logic [CNT_W-1:0]   rem;
  logic [NUM_W-1:0]   quo;

  logic               in_fire, out_fire, bump, rem_ge, lut_wr;
  logic [CNT_W-1:0]   hist_rd, cdf_next, cdf_off, den, rem_next;
  logic [CNT_W:0]     rem_sh;
  logic [NUM_W-1:0]   num_init, quo_next;
  logic [PIX_W-1:0]   quo_sat, lut_val;

  assign busy     = (state != StIdle);
  assign in_ready = (state == StHist) ||
                    ((state == StMap) && map_open && (!out_valid || out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign hist_rd  = hist[in_pixel];
  assign cdf_next = cdf_run + hist[bin];

`ifdef HE_CLIP_EN
  assign bump = (clip_limit == '0) || (hist_rd < clip_limit);
`else
  logic unused_clip;
  assign bump        = 1'b1;
  assign unused_clip = ^clip_limit;
`endif

  // Numerator (cdf - cdf_min) * (NB - 1) as a shift-and-subtract; one restoring step per cycle.
  assign cdf_off  = hist[bin] - cdf_min;
  assign den      = total - cdf_min;
  assign num_init = ({{PIX_W{1'b0}}, cdf_off} << PIX_W) - {{PIX_W{1'b0}}, cdf_off};
  assign rem_sh   = {rem, quo[NUM_W-1]};
  assign rem_ge   = rem_sh >= {1'b0, den};
  assign rem_next = rem_ge ? (rem_sh[CNT_W-1:0] - den) : rem_sh[CNT_W-1:0];
  assign quo_next = {quo[NUM_W-2:0], rem_ge};
  assign quo_sat  = (|quo_next[NUM_W-1:PIX_W]) ? MaxBin : quo_next[PIX_W-1:0];

  always_comb begin
    lut_wr  = 1'b0;
    lut_val = '0;
    if (!div_busy) begin
      if (total == cdf_min) begin
        lut_wr  = 1'b1;
        lut_val = bin;
      end else if (hist[bin] < cdf_min) begin
        lut_wr  = 1'b1;
      end
    end else if (div_cnt == '0) begin
      lut_wr  = 1'b1;
      lut_val = quo_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      bin       <= '0;
      pix_cnt   <= '0;
      cdf_run   <= '0;
      cdf_min   <= '0;
      total     <= '0;
      found     <= 1'b0;
      map_open  <= 1'b0;
      div_busy  <= 1'b0;
      div_cnt   <= '0;
      rem       <= '0;
      quo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StClear;
            bin   <= '0;
          end
        end
        StClear: begin
          hist[bin] <= '0;
          bin       <= bin + 1'b1;
          pix_cnt   <= '0;
          if (bin == MaxBin) state <= StHist;
        end
        StHist: begin
          if (in_fire) begin
            if (bump) hist[in_pixel] <= hist_rd + 1'b1;
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == LastPix) begin
              state   <= StCdf;
              cdf_run <= '0;
              found   <= 1'b0;
            end
          end
        end
        StCdf: begin
          hist[bin] <= cdf_next;
          cdf_run   <= cdf_next;
          bin       <= bin + 1'b1;
          if (!found && (hist[bin] != '0)) begin
            found   <= 1'b1;
            cdf_min <= cdf_next;
          end
          if (bin == MaxBin) begin
            total    <= cdf_next;
            state    <= StLut;
            div_busy <= 1'b0;
          end
        end
        StLut: begin
          if (div_busy) begin
            rem     <= rem_next;
            quo     <= quo_next;
            div_cnt <= div_cnt - 1'b1;
          end else if (!lut_wr) begin
            div_busy <= 1'b1;
            rem      <= '0;
            quo      <= num_init;
            div_cnt  <= DivLast;
          end
          if (lut_wr) begin
            lut[bin] <= lut_val;
            div_busy <= 1'b0;
            bin      <= bin + 1'b1;
            if (bin == MaxBin) begin
              state    <= StMap;
              map_open <= 1'b1;
              pix_cnt  <= '0;
            end
          end
        end
        StMap: begin
          if (in_fire) begin
            out_pixel <= lut[in_pixel];
            out_valid <= 1'b1;
            out_last  <= (pix_cnt == LastPix);
            pix_cnt   <= pix_cnt + 1'b1;
            if (pix_cnt == LastPix) map_open <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (out_fire && out_last) begin
            state <= StDone;
            done  <= 1'b1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_he_stream_eq.sv
// Directed bench for he_stream_eq: reference LUT model feeds a scoreboard queue in pass 2.
module tb_he_stream_eq;

  localparam int unsigned PW   = 8;
  localparam int unsigned CW   = 8;
  localparam int unsigned NPIX = 16;
  localparam int unsigned NB   = 256;
`ifdef HE_CLIP_EN
  localparam bit ClipOn = 1'b1;
`else
  localparam bit ClipOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [CW-1:0] clip_limit;
  logic [PW-1:0] in_pixel, out_pixel;

  he_stream_eq #(.PIX_W(PW), .IMG_W(4), .IMG_H(4), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clip_limit (clip_limit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int            vectors, errors;
  int            in_idx, hs_cnt, done_cnt;
  logic [PW-1:0] frame [NPIX];
  logic [PW-1:0] lut_m [NB];
  logic [PW-1:0] expq [$];
  logic          stall_prev;
  logic [PW-1:0] stall_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void build_model(input int clip);
    int h [NB];
    int c [NB];
    int run, cmin, tot, q;
    bit found;
    for (int v = 0; v < NB; v++) h[v] = 0;
    for (int i = 0; i < NPIX; i++)
      if (!ClipOn || clip == 0 || h[frame[i]] < clip) h[frame[i]]++;
    run = 0; found = 0; cmin = 0;
    for (int v = 0; v < NB; v++) begin
      run += h[v];
      c[v] = run;
      if (!found && h[v] != 0) begin
        found = 1;
        cmin  = run;
      end
    end
    tot = run;
    for (int v = 0; v < NB; v++) begin
      if (tot == cmin) lut_m[v] = PW'(v);
      else if (c[v] < cmin) lut_m[v] = '0;
      else begin
        q = (c[v] - cmin) * (NB - 1) / (tot - cmin);
        lut_m[v] = (q > NB - 1) ? PW'(NB - 1) : PW'(q);
      end
    end
  endfunction

  // One clock: outputs judged at the falling edge, inputs driven then, handshakes resolved #1 later.
  task automatic cycle(input bit iv, input bit ordy, input bit pass2);
    logic [PW-1:0] e;
    @(negedge clk);
    out_ready = ordy;
    if (stall_prev) check("stall_hold", out_pixel, stall_pix);
    if (out_valid && ordy) begin
      hs_cnt++;
      if (expq.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL spurious_out: observed pixel %0d, expected no output", out_pixel);
      end else begin
        e = expq.pop_front();
        check("out_pixel", out_pixel, e);
        check("out_last", out_last, hs_cnt == NPIX);
      end
    end
    stall_prev = out_valid && !ordy;
    stall_pix  = out_pixel;
    in_valid   = iv && (in_idx < NPIX);
    in_pixel   = frame[(in_idx < NPIX) ? in_idx : 0];
    #1;
    if (out_valid && !ordy) check("ready_bp", in_ready, 0);
    if (in_valid && in_ready) begin
      if (pass2) expq.push_back(lut_m[in_pixel]);
      in_idx++;
    end
    if (done) done_cnt++;
  endtask

  task automatic kick();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after_start", busy, 1);
  endtask

  task automatic pass1(input bit gap, input int upto, input bit poke);
    int n;
    n = 0;
    in_idx = 0;
    while (in_idx < upto && n < 5000) begin
      start = poke && (n == 3 || n == 270);
      cycle(!gap || (n % 3 != 1), 1'b1, 1'b0);
      n++;
    end
    start = 1'b0;
    if (in_idx < upto) begin
      vectors++;
      errors++;
      $error("FAIL timeout_pass1: observed %0d accepts, expected %0d", in_idx, upto);
    end
  endtask

  task automatic run_frame(input bit bp, input int clip, input bit poke);
    int n;
    clip_limit = CW'(clip);
    build_model(clip);
    expq.delete();
    hs_cnt = 0; done_cnt = 0; stall_prev = 1'b0;
    kick();
    pass1(bp, NPIX, poke);
    n = 0;
    in_idx = 0;
    while (hs_cnt < NPIX && n < 10000) begin
      cycle(!bp || (n % 3 != 1), !bp || (n % 4 == 0) || (n % 4 == 3), 1'b1);
      n++;
    end
    check("handshakes", hs_cnt, NPIX);
    repeat (4) cycle(1'b0, 1'b1, 1'b1);
    check("done_pulses", done_cnt, 1);
    check("idle_after_done", busy, 0);
    check("queue_empty", expq.size(), 0);
  endtask

  initial begin
    vectors = 0; errors = 0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    clip_limit = '0; stall_prev = 1'b0; in_idx = 0; hs_cnt = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    for (int i = 0; i < NPIX; i++) frame[i] = PW'(i * 16);
    run_frame(1'b0, 0, 1'b0);

    for (int i = 0; i < NPIX; i++) frame[i] = PW'(100);
    run_frame(1'b0, 0, 1'b0);

    for (int i = 0; i < NPIX; i++) frame[i] = (i < 8) ? PW'(10) : PW'(200);
    run_frame(1'b0, 0, 1'b0);

    for (int i = 0; i < NPIX; i++) frame[i] = PW'(i * 16);
    run_frame(1'b1, 0, 1'b0);

    // Abort after five histogram accepts.
    kick();
    pass1(1'b0, 5, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_done", done, 0);
    stall_prev = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check("abort_quiet", out_valid, 0);
    end
    run_frame(1'b0, 0, 1'b1);

    for (int i = 0; i < NPIX; i++) frame[i] = (i < 2) ? PW'(50) : (i < 12) ? PW'(100) : PW'(150);
    run_frame(1'b0, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
